la_clkdivn: RTL

Multi-channel programmable clock divider, the parametrised successor to the single 2-input clock XOR cell. It generates N independent divided clocks from one source clock, each with a runtime divide ratio and an optional XOR phase inversion that is applied glitch-free at period boundaries. It sits in clock-generation logic, feeding slow peripheral clocks, strobe clocks and phase-inverted clock pairs.

---
 rtl/la_clkdivn.sv | 120 ++++++++++++
 1 files changed

// File: rtl/la_clkdivn.sv
// N-channel programmable clock divider: glitch-free ratio/inversion reload at period boundaries.
// One-cycle start latency; optional output inversion built when LA_CLKDIVN_INV_EN is defined.
module la_clkdivn #(
    parameter int N    = 1,
    parameter int DW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    en,
    input  logic [N*DW-1:0] div,
    input  logic [N-1:0]    inv,
    input  logic            sync,
    output logic [N-1:0]    clkout,
    output logic [N-1:0]    running
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam bit PROP_DEFAULT = (PROP == "DEFAULT");

    state_t        state_q [N];
    state_t        state_d [N];
    logic [DW-1:0] d_q     [N];
    logic [DW-1:0] d_d     [N];
    logic [DW-1:0] cnt_q   [N];
    logic [DW-1:0] cnt_d   [N];
    logic [DW-1:0] div_a   [N];
    logic [DW-1:0] cnt_inc [N];
    logic [N-1:0]  load_ok;
    logic [N-1:0]  r_d;
    logic [N-1:0]  v_d;
    logic [N-1:0]  out_d;

`ifdef LA_CLKDIVN_INV_EN
    logic [N-1:0]  v_q;
    logic          unused_cfg;
    assign unused_cfg = PROP_DEFAULT;
    assign out_d      = r_d ^ v_d;
`else
    logic          unused_cfg;
    assign unused_cfg = PROP_DEFAULT ^ (^inv) ^ (^v_d);
    assign out_d      = r_d;
`endif

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign div_a[g]   = div[g*DW +: DW];
        assign load_ok[g] = en[g] && (div_a[g] >= DW'(2));
        assign cnt_inc[g] = cnt_q[g] + DW'(1);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            d_d[i]     = d_q[i];
            cnt_d[i]   = cnt_q[i];
            r_d[i]     = 1'b0;
`ifdef LA_CLKDIVN_INV_EN
            v_d[i]     = v_q[i];
`else
            v_d[i]     = 1'b0;
`endif
            case (state_q[i])
                IDLE: begin
                    if (load_ok[i]) begin
                        state_d[i] = RUN;
                        d_d[i]     = div_a[i];
                        v_d[i]     = inv[i];
                        cnt_d[i]   = '0;
                        r_d[i]     = 1'b1;
                    end
                end
                RUN: begin
                    // sync forces a boundary; the old period is otherwise never cut short
                    if (sync || (cnt_q[i] == d_q[i] - DW'(1))) begin
                        cnt_d[i] = '0;
                        if (load_ok[i]) begin
                            d_d[i] = div_a[i];
                            v_d[i] = inv[i];
                            r_d[i] = 1'b1;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else begin
                        cnt_d[i] = cnt_inc[i];
                        r_d[i]   = (cnt_inc[i] < (d_q[i] - (d_q[i] >> 1)));
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                d_q[i]     <= '0;
                cnt_q[i]   <= '0;
            end
`ifdef LA_CLKDIVN_INV_EN
            v_q     <= '0;
`endif
            clkout  <= '0;
            running <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                d_q[i]     <= d_d[i];
                cnt_q[i]   <= cnt_d[i];
                running[i] <= (state_d[i] == RUN);
            end
`ifdef LA_CLKDIVN_INV_EN
            v_q     <= v_d;
`endif
            clkout  <= out_d;
        end
    end

endmodule
